// File: rtl/fa_pkg.sv
// rtl/fa_pkg.sv - shared FIR/FFT constants, complex word type and bit-reverse helper
package fa_pkg;

  localparam int FFT_N  = 16;
  localparam int FIR_DW = 16;

  typedef struct packed {
    logic signed [FIR_DW-1:0] re;
    logic signed [FIR_DW-1:0] im;
  } cplx_t;

  // Reverse the low log2n bits of idx; used to build constant slot maps.
  function automatic int bitrev(input int idx, input int log2n);
    int r;
    r = 0;
    for (int b = 0; b < log2n; b++) begin
      if (((idx >> b) & 1) != 0) r = r | (1 << (log2n - 1 - b));
    end
    return r;
  endfunction

endpackage

// File: rtl/stp_framer_if.sv
// rtl/stp_framer_if.sv - sample input / frame output handshake bundle of the framer
interface stp_framer_if #(
  parameter int DW   = 16,
  parameter int N    = 16,
  parameter int CNTW = 16
);
  logic              clr;
  logic              fir_valid;
  logic [DW-1:0]     fir_d;
  logic              fir_ready;
  logic              fft_valid;
  logic              fft_ready;
  logic [N*2*DW-1:0] fft_data;
  logic [CNTW-1:0]   frame_cnt;

  modport master (
    output clr, fir_valid, fir_d, fft_ready,
    input  fir_ready, fft_valid, fft_data, frame_cnt
  );

  modport slave (
    input  clr, fir_valid, fir_d, fft_ready,
    output fir_ready, fft_valid, fft_data, frame_cnt
  );
endinterface

// File: rtl/stp_win_ctrl.sv
// rtl/stp_win_ctrl.sv - window fill / hop counting and the two-sided ready/valid handshake
module stp_win_ctrl #(
  parameter int N   = 16,
  parameter int HOP = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic fir_valid,
  input  logic fft_ready,
  output logic fir_ready,
  output logic fft_valid,
  output logic accept,
  output logic load
);

  localparam int FW = $clog2(N + 1);
  localparam int HW = $clog2(HOP + 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(N);
  localparam logic [FW-1:0] FILL_LAST = FW'(N - 1);
  localparam logic [HW-1:0] HOP_LAST  = HW'(HOP - 1);

  logic [FW-1:0] fill;
  logic [HW-1:0] hop_cnt;
  logic          trigger_pending;

  // The next accepted sample completes a frame; only such a sample may be
  // stalled, and only while the previous frame is still waiting downstream.
  always_comb begin
    trigger_pending = (fill == FILL_LAST) || ((fill == FILL_FULL) && (hop_cnt == HOP_LAST));
    fir_ready       = !RST && !clr && !(trigger_pending && fft_valid && !fft_ready);
    accept          = fir_valid && fir_ready;
    load            = accept && trigger_pending;
  end

  // Fill/hop bookkeeping and the output-valid flag; clr flushes the window
  // but leaves a held frame to drain normally.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fill      <= '0;
      hop_cnt   <= '0;
      fft_valid <= 1'b0;
    end else begin
      if (clr) begin
        fill    <= '0;
        hop_cnt <= '0;
      end else if (accept) begin
        if (fill != FILL_FULL) begin
          fill <= fill + FW'(1);
        end else if (hop_cnt == HOP_LAST) begin
          hop_cnt <= '0;
        end else begin
          hop_cnt <= hop_cnt + HW'(1);
        end
      end
      if (load) begin
        fft_valid <= 1'b1;
      end else if (fft_ready) begin
        fft_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/stp_framer.sv
// rtl/stp_framer.sv - serial-to-parallel framer: sample window, complex packing, frame register
module stp_framer
  import fa_pkg::*;
#(
  parameter int DW     = FIR_DW,
  parameter int N      = FFT_N,
  parameter int HOP    = 16,
  parameter int BITREV = 0,
  parameter int CNTW   = 16
) (
  input  logic         CLK,
  input  logic         RST,
  stp_framer_if.slave  bus
);

  localparam int LOG2N = $clog2(N);

  if ((N < 4) || (N > 256) || ((N & (N - 1)) != 0)) begin : g_bad_n
    $error("stp_framer: N must be a power of 2 in 4..256");
  end
  if ((HOP < 1) || (HOP > N)) begin : g_bad_hop
    $error("stp_framer: HOP must be in 1..N");
  end

  logic              accept;
  logic              load;
  logic [DW-1:0]     win    [N];
  logic [DW-1:0]     win_nx [N];
  logic [N*2*DW-1:0] frame_nx;
  logic [N*2*DW-1:0] fft_data_q;
  logic [CNTW-1:0]   frame_cnt_q;

  stp_win_ctrl #(
    .N   (N),
    .HOP (HOP)
  ) u_ctrl (
    .CLK       (CLK),
    .RST       (RST),
    .clr       (bus.clr),
    .fir_valid (bus.fir_valid),
    .fft_ready (bus.fft_ready),
    .fir_ready (bus.fir_ready),
    .fft_valid (bus.fft_valid),
    .accept    (accept),
    .load      (load)
  );

  // Window as it will be after this cycle's sample shifts in, so a trigger
  // sample lands in the frame it completes.
  always_comb begin
    for (int i = 0; i < N - 1; i++) begin
      win_nx[i] = win[i + 1];
    end
    win_nx[N-1] = bus.fir_d;
  end

  // Shift register: win[0] oldest, win[N-1] newest; contents need no reset.
  always_ff @(posedge CLK) begin
    if (accept) win <= win_nx;
  end

  // Slot k carries the real sample in the upper half and a zero imaginary part.
  for (genvar k = 0; k < N; k++) begin : g_pack
    localparam int SRC = (BITREV != 0) ? bitrev(k, LOG2N) : k;
    assign frame_nx[k*2*DW +: 2*DW] = {win_nx[SRC], {DW{1'b0}}};
  end

  // Frame register and frame counter, loaded on the edge accepting a trigger.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fft_data_q  <= '0;
      frame_cnt_q <= '0;
    end else if (load) begin
      fft_data_q  <= frame_nx;
      frame_cnt_q <= frame_cnt_q + CNTW'(1);
    end
  end

  assign bus.fft_data  = fft_data_q;
  assign bus.frame_cnt = frame_cnt_q;

endmodule
